// File: rtl/vga_axil_pkg.sv
// Shared types for the VGA AXI-Lite command bridge.
// Holds the default AXI-Lite address/data types, the AXI response codes
// and the bridge FSM state encoding.
// Optional feature macro used by the top: VGA_AXIL_SVA_EN (protocol assertions).
package vga_axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0] axil_data_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } axil_state_e;

  // Map a raw 2-bit bus response onto the response enum.
  function automatic axil_resp_e to_resp(input logic [1:0] raw);
    axil_resp_e r;
    case (raw)
      2'd0:    r = OKAY;
      2'd1:    r = EXOKAY;
      2'd2:    r = SLVERR;
      2'd3:    r = DECERR;
      default: r = SLVERR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vga_axil_if.sv
// vga_axil_if: single-outstanding command-to-AXI-Lite master bridge.
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command request side
//   rsp_valid/resp/rdata        one-cycle completion pulse plus held result
//   aw*/w*/b*/ar*/r*            AXI-Lite master channels
// All outputs are registered. AW and W are issued together and retired
// independently; the B phase starts only once both have handshaken.
// Optional: define VGA_AXIL_SVA_EN to compile in protocol assertions.
module vga_axil_if
  import vga_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  axil_state_e       state_r;
  logic              cmd_ready_r;
  logic              awvalid_r;
  logic              wvalid_r;
  logic              arvalid_r;
  logic              bready_r;
  logic              rready_r;
  logic              rsp_valid_r;
  axil_resp_e        rsp_resp_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  // A channel stays pending while its valid is up and the slave has not taken it.
  logic aw_pend_s;
  logic w_pend_s;
  assign aw_pend_s = awvalid_r && !awready;
  assign w_pend_s  = wvalid_r && !wready;

  // Bridge FSM with all handshake and response outputs registered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_resp_r  <= SLVERR;
      awaddr_r    <= '0;
      araddr_r    <= '0;
      wdata_r     <= '0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (cmd_write) begin
              awaddr_r  <= cmd_addr;
              wdata_r   <= cmd_wdata;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= ST_WR_REQ;
            end else begin
              araddr_r  <= cmd_addr;
              arvalid_r <= 1'b1;
              state_r   <= ST_RD_REQ;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          // Each channel drops its valid on its own handshake.
          awvalid_r <= aw_pend_s;
          wvalid_r  <= w_pend_s;
          if (!aw_pend_s && !w_pend_s) begin
            bready_r <= 1'b1;
            state_r  <= ST_WR_RESP;
          end else begin
            bready_r <= 1'b0;
          end
        end
        ST_WR_RESP: begin
          if (bvalid && bready_r) begin
            bready_r    <= 1'b0;
            rsp_resp_r  <= to_resp(bresp);
            rsp_valid_r <= 1'b1;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            bready_r <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (arvalid_r && arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_RD_RESP;
          end else begin
            arvalid_r <= 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (rvalid && rready_r) begin
            rready_r    <= 1'b0;
            rsp_rdata_r <= rdata;
            rsp_resp_r  <= to_resp(rresp);
            rsp_valid_r <= 1'b1;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            rready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          bready_r    <= 1'b0;
          rready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_resp  = rsp_resp_r;
  assign rsp_rdata = rsp_rdata_r;
  assign awaddr    = awaddr_r;
  assign awvalid   = awvalid_r;
  assign wdata     = wdata_r;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;
  assign araddr    = araddr_r;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;

`ifdef VGA_AXIL_SVA_EN
  a_aw_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (awvalid && !awready) |=> (awvalid && $stable(awaddr)))
    else $error("vga_axil_if: AW changed while stalled");
  a_w_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (wvalid && !wready) |=> (wvalid && $stable(wdata)))
    else $error("vga_axil_if: W changed while stalled");
  a_ar_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)))
    else $error("vga_axil_if: AR changed while stalled");
  a_no_x: assert property (@(posedge clk) disable iff (!arst_n)
    !$isunknown({cmd_ready, rsp_valid, rsp_resp, rsp_rdata, awaddr, awvalid,
                 wdata, wvalid, bready, araddr, arvalid, rready}))
    else $error("vga_axil_if: X on outputs");
  a_rsp_after_cmd: assert property (@(posedge clk) disable iff (!arst_n)
    rsp_valid |-> $past(state_r == ST_WR_RESP || state_r == ST_RD_RESP))
    else $error("vga_axil_if: rsp_valid without command");
  a_bvalid_expected: assert property (@(posedge clk) disable iff (!arst_n)
    bvalid |-> (state_r == ST_WR_RESP))
    else $error("vga_axil_if: unexpected bvalid");
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!arst_n)
    rvalid |-> (state_r == ST_RD_RESP))
    else $error("vga_axil_if: unexpected rvalid");
`endif

endmodule

// File: tb/tb_vga_axil_if.sv
// Directed self-checking bench for vga_axil_if with a hand-driven AXI-Lite slave.
module tb_vga_axil_if;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_axil_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 arst_n = 1'b0;
    #2;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, araddr, wdata, rsp_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {awaddr, araddr, wdata, rsp_rdata});
    end
    checks++;
    if (rsp_resp !== 2'd2) begin failures++; $display("FAIL reset_resp got=%0d exp=2", rsp_resp); end
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL post_reset got=%b exp=10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_zero_wait_write();
    idle_inputs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3; cmd_wdata = 32'h4;
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({awvalid, wvalid, cmd_ready, bready} !== 4'b1100) begin
      failures++; $display("FAIL zw_issue got=%b exp=1100", {awvalid, wvalid, cmd_ready, bready});
    end
    checks++;
    if (awaddr !== 32'h3 || wdata !== 32'h4) begin
      failures++; $display("FAIL zw_beat got=%h/%h exp=3/4", awaddr, wdata);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      failures++; $display("FAIL zw_bphase got=%b exp=0010", {awvalid, wvalid, bready, rsp_valid});
    end
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'd0;
    tick();
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp, bready, cmd_ready} !== 5'b1_00_01) begin
      failures++; $display("FAIL zw_rsp got=%b exp=10001", {rsp_valid, rsp_resp, bready, cmd_ready});
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_resp !== 2'd0) begin
      failures++; $display("FAIL zw_pulse got=%b/%0d exp=0/0", rsp_valid, rsp_resp);
    end
  endtask

  task automatic test_read_back();
    idle_inputs();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({arvalid, rready, awvalid} !== 3'b100 || araddr !== 32'h3) begin
      failures++; $display("FAIL rd_issue got=%b addr=%h exp=100 addr=3", {arvalid, rready, awvalid}, araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    checks++;
    if ({arvalid, rready} !== 2'b01) begin failures++; $display("FAIL rd_rphase got=%b exp=01", {arvalid, rready}); end
    rvalid = 1'b1; rdata = 32'h4; rresp = 2'd0;
    tick();
    rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp} !== 3'b100 || rsp_rdata !== 32'h4) begin
      failures++; $display("FAIL rd_rsp got=%b data=%h exp=100 data=4", {rsp_valid, rsp_resp}, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b%b exp=00", rsp_valid, rready); end
  endtask

  task automatic test_skewed();
    idle_inputs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFE;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL sk_issue got=%b exp=11", {awvalid, wvalid}); end
    tick();
    awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wready = 1'b1;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'hCAFE) begin
        failures++; $display("FAIL sk_wait%0d got=%b data=%h exp=010 data=cafe", i, {awvalid, wvalid, bready}, wdata);
      end
      tick();
    end
    wready = 1'b0;
    checks++;
    if ({wvalid, bready} !== 2'b01) begin failures++; $display("FAIL sk_bphase got=%b exp=01", {wvalid, bready}); end
    bvalid = 1'b1; bresp = 2'd0;
    tick();
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp} !== 3'b100) begin failures++; $display("FAIL sk_rsp got=%b exp=100", {rsp_valid, rsp_resp}); end
  endtask

  task automatic test_delayed_err();
    idle_inputs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hAA;
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h99; cmd_wdata = 32'h77;
      end
      checks++;
      if ({bready, rsp_valid, cmd_ready, awvalid} !== 4'b1000) begin
        failures++; $display("FAIL de_bwait%0d got=%b exp=1000", i, {bready, rsp_valid, cmd_ready, awvalid});
      end
      tick();
    end
    cmd_valid = 1'b0;
    bvalid = 1'b1; bresp = 2'd2;
    tick();
    bvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp} !== 3'b110 || rsp_rdata !== 32'h4) begin
      failures++; $display("FAIL de_wr_rsp got=%b data=%h exp=110 data=4", {rsp_valid, rsp_resp}, rsp_rdata);
    end
    tick();
    checks++;
    if ({awvalid, rsp_valid, cmd_ready} !== 3'b001) begin failures++; $display("FAIL de_ignored got=%b exp=001", {awvalid, rsp_valid, cmd_ready}); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'hC) begin
        failures++; $display("FAIL de_arwait%0d got=%b addr=%h exp=1 addr=c", i, arvalid, araddr);
      end
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL de_rwait%0d got=%b exp=10", i, {rready, rsp_valid}); end
      tick();
    end
    rvalid = 1'b1; rdata = 32'hDEAD; rresp = 2'd3;
    tick();
    rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp} !== 3'b111 || rsp_rdata !== 32'hDEAD) begin
      failures++; $display("FAIL de_rd_rsp got=%b data=%h exp=111 data=dead", {rsp_valid, rsp_resp}, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11;
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    awready = 1'b0; wready = 1'b0;
    checks++;
    if (bready !== 1'b1) begin failures++; $display("FAIL rm_in_bphase got=%b exp=1", bready); end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0000001 || rsp_resp !== 2'd2) begin
      failures++; $display("FAIL rm_async got=%b resp=%0d exp=0000001 resp=2", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, rsp_resp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_no_rsp got=%b exp=0", rsp_valid); end
    arst_n = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h10 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rm_rd_issue got=%b addr=%h exp=1 addr=10", arvalid, araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h55; rresp = 2'd0;
    tick();
    rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp} !== 3'b100 || rsp_rdata !== 32'h55) begin
      failures++; $display("FAIL rm_rd_rsp got=%b data=%h exp=100 data=55", {rsp_valid, rsp_resp}, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, mem_a, mem_d, cap_a, cap_d;
    int n;
    idle_inputs();
    mem_a = 32'h0; mem_d = 32'h0;
    for (int it = 0; it < 100; it++) begin
      a = $urandom; d = $urandom;
      cap_a = 32'h0; cap_d = 32'h0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
      awready = 1'b1; wready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!bready && n < 10) begin
        if (awvalid && awready) cap_a = awaddr;
        if (wvalid && wready) cap_d = wdata;
        tick();
        n++;
      end
      awready = 1'b0; wready = 1'b0;
      checks++;
      if (bready !== 1'b1) begin failures++; $display("FAIL bb_wr_timeout it=%0d got=%b exp=1", it, bready); end
      mem_a = cap_a; mem_d = cap_d;
      bvalid = 1'b1; bresp = 2'd0;
      tick();
      bvalid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_resp} !== 3'b100) begin failures++; $display("FAIL bb_wr_rsp it=%0d got=%b exp=100", it, {rsp_valid, rsp_resp}); end
      cap_a = 32'hFFFF_FFFF;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
      arready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rready && n < 10) begin
        if (arvalid && arready) cap_a = araddr;
        tick();
        n++;
      end
      arready = 1'b0;
      checks++;
      if (rready !== 1'b1) begin failures++; $display("FAIL bb_rd_timeout it=%0d got=%b exp=1", it, rready); end
      rvalid = 1'b1; rresp = 2'd0;
      rdata = (cap_a == mem_a) ? mem_d : 32'hBAD0_BAD0;
      tick();
      rvalid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d) begin
        failures++; $display("FAIL bb_rd_data it=%0d got=%h exp=%h", it, rsp_rdata, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_back();
    test_skewed();
    test_delayed_err();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
